adder_ctrl: RTL



---
 rtl/adder_ctrl_pkg.sv | 28 ++
 rtl/adder_slice.sv | 18 +
 rtl/adder_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/adder_ctrl_pkg.sv
// Shared register map, bit positions, FSM state type and parameter checks
// for the adder_ctrl register bank.
package adder_ctrl_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_OP_A   = 8'h08;
    localparam logic [7:0] ADDR_OP_B   = 8'h0C;
    localparam logic [7:0] ADDR_RESULT = 8'h10;

    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_CLR_DONE = 1;
    localparam int unsigned CTRL_IRQ_EN   = 2;

    localparam int unsigned STAT_BUSY  = 0;
    localparam int unsigned STAT_DONE  = 1;
    localparam int unsigned STAT_CARRY = 2;

    typedef enum logic {
        st_idle = 1'b0,
        st_run  = 1'b1
    } state_t;

    function automatic bit chunk_w_legal(input int unsigned w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8) || (w == 16) || (w == 32);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple slice used by the iterative sequencer.
module adder_slice #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] w_sum;

    assign w_sum   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign s       = w_sum[W-1:0];
    assign cout    = w_sum[W];

endmodule

// File: rtl/adder_ctrl.sv
// Register bank and CHUNK_W-bit-per-cycle sequencer for the 32-bit adder IP,
// sitting behind the AXI4-Lite slave's register ports.
module adder_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int unsigned CHUNK_W = 8
) (
    input  logic        ACLK,
    input  logic        ARSTn,
    input  logic        i_en_amba_write,
    input  logic [31:0] i_data_wc,
    input  logic [31:0] i_addr_wc,
    input  logic [3:0]  i_strb,
    input  logic [31:0] i_addr_rc,
    output logic [31:0] o_data_rc,
    output logic        o_is_busy,
    output logic        o_done_irq
);

    if (!chunk_w_legal(CHUNK_W)) begin : g_chunk_w_illegal
        $error("adder_ctrl: CHUNK_W must be one of 1, 2, 4, 8, 16, 32");
    end

    localparam int unsigned N_STEPS = 32 / CHUNK_W;
    localparam int unsigned STEP_W  = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

    state_t              r_state;
    logic [31:0]         r_op_a;
    logic [31:0]         r_op_b;
    logic [31:0]         r_result;
    logic                r_done;
    logic                r_carry;
    logic                r_irq_en;
    logic [STEP_W-1:0]   r_step;
    logic                r_cin;
    logic                r_busy;

    logic                w_wr_hit;
    logic [7:0]          w_wr_off;
    logic                w_wr_ctrl;
    logic                w_wr_op_a;
    logic                w_wr_op_b;
    logic                w_start;
    logic                w_clr_done;
    logic [31:0]         w_op_a_mrg;
    logic [31:0]         w_op_b_mrg;
    logic [4:0]          w_base;
    logic [CHUNK_W-1:0]  w_a_sl;
    logic [CHUNK_W-1:0]  w_b_sl;
    logic [CHUNK_W-1:0]  w_sum_sl;
    logic                w_cout;
    logic                w_unused;

    assign w_unused = &{1'b0, i_addr_wc[1:0], i_addr_rc[1:0]};

    always_comb begin
        w_wr_hit   = i_en_amba_write && (i_addr_wc[31:8] == '0);
        w_wr_off   = {i_addr_wc[7:2], 2'b00};
        w_wr_ctrl  = w_wr_hit && (w_wr_off == ADDR_CTRL) && i_strb[0];
        w_wr_op_a  = w_wr_hit && (w_wr_off == ADDR_OP_A);
        w_wr_op_b  = w_wr_hit && (w_wr_off == ADDR_OP_B);
        w_start    = w_wr_ctrl && i_data_wc[CTRL_START];
        w_clr_done = w_wr_ctrl && i_data_wc[CTRL_CLR_DONE];
        w_op_a_mrg = r_op_a;
        w_op_b_mrg = r_op_b;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i_strb[i]) begin
                w_op_a_mrg[8*i +: 8] = i_data_wc[8*i +: 8];
                w_op_b_mrg[8*i +: 8] = i_data_wc[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_base = 5'(r_step * CHUNK_W);
        w_a_sl = r_op_a[w_base +: CHUNK_W];
        w_b_sl = r_op_b[w_base +: CHUNK_W];
    end

    adder_slice #(.W(CHUNK_W)) u_slice (
        .a    (w_a_sl),
        .b    (w_b_sl),
        .cin  (r_cin),
        .s    (w_sum_sl),
        .cout (w_cout)
    );

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            r_state  <= st_idle;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_carry  <= 1'b0;
            r_irq_en <= 1'b0;
            r_step   <= '0;
            r_cin    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_irq_en <= i_data_wc[CTRL_IRQ_EN];
            end
            case (r_state)
                st_idle: begin
                    if (w_wr_op_a) r_op_a <= w_op_a_mrg;
                    if (w_wr_op_b) r_op_b <= w_op_b_mrg;
                    // START outranks CLR_DONE; both leave DONE/CARRY at 0 anyway.
                    if (w_start) begin
                        r_state  <= st_run;
                        r_busy   <= 1'b1;
                        r_step   <= '0;
                        r_cin    <= 1'b0;
                        r_done   <= 1'b0;
                        r_carry  <= 1'b0;
                        r_result <= '0;
                    end else if (w_clr_done) begin
                        r_done   <= 1'b0;
                        r_carry  <= 1'b0;
                    end
                end
                st_run: begin
                    r_result[w_base +: CHUNK_W] <= w_sum_sl;
                    r_cin  <= w_cout;
                    r_step <= r_step + 1'b1;
                    if (r_step == LAST_STEP) begin
                        r_state <= st_idle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_carry <= w_cout;
                    end
                end
                default: r_state <= st_idle;
            endcase
        end
    end

    always_comb begin
        o_data_rc = '0;
        if (i_addr_rc[31:8] == '0) begin
            case ({i_addr_rc[7:2], 2'b00})
                ADDR_CTRL:   o_data_rc[CTRL_IRQ_EN] = r_irq_en;
                ADDR_STATUS: o_data_rc[2:0] = {r_carry, r_done, r_busy};
                ADDR_OP_A:   o_data_rc = r_op_a;
                ADDR_OP_B:   o_data_rc = r_op_b;
                ADDR_RESULT: o_data_rc = r_result;
                default:     o_data_rc = '0;
            endcase
        end
    end

    assign o_is_busy  = r_busy;
    assign o_done_irq = r_done & r_irq_en;

endmodule
